// File: rtl/load_store_unit.sv
// In-order load/store front end for the PE data memory: request FIFO feeding the
// memory ports, with a single registered load-response slot on a valid/ready port.
module load_store_unit #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_a,
  output logic [DATA_W-1:0]          mem_wd,
  input  logic [DATA_W-1:0]          mem_rd,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a full FIFO refuses even if it pops.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    HD_EMPTY,
    HD_STORE,
    HD_LOAD_GO,
    HD_LOAD_STALL
  } head_e;

  logic              q_we    [DEPTH];
  logic [ADDR_W-1:0] q_addr  [DEPTH];
  logic [DATA_W-1:0] q_wdata [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  head_e            head;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pending   = count;

  always_comb begin
    head = HD_EMPTY;
    if (!empty) begin
      if (q_we[rd_ptr])                  head = HD_STORE;
      else if (!rsp_valid || rsp_ready)  head = HD_LOAD_GO;
      else                               head = HD_LOAD_STALL;
    end
  end

  // A stalled load keeps its address on the bus; younger entries wait behind it.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    pop    = 1'b0;
    unique case (head)
      HD_STORE: begin
        mem_we = rst;
        mem_a  = q_addr[rd_ptr];
        mem_wd = q_wdata[rd_ptr];
        pop    = 1'b1;
      end
      HD_LOAD_GO: begin
        mem_a = q_addr[rd_ptr];
        pop   = 1'b1;
      end
      HD_LOAD_STALL: begin
        mem_a = q_addr[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_we[wr_ptr]    <= req_we;
      q_addr[wr_ptr]  <= req_addr;
      q_wdata[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A load leaving the FIFO overwrites the slot; otherwise a consumed response empties it.
      if (head == HD_LOAD_GO) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem_rd;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a behavioural data memory
// and a shadow memory that predicts every load response in request order.
module tb_load_store_unit;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [DATA_W-1:0] INIT_WORD = {8{32'hBEEFCAFE}};
  localparam logic [DATA_W-1:0] A5_WORD   = {8{32'h0000_00A5}};
  localparam logic [DATA_W-1:0] X_WORD    = {8{32'h7777_1234}};

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  logic [CNT_W-1:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem     [1024];
  logic [DATA_W-1:0] ref_mem [1024];
  bit rand_ready = 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  load_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .pending(pending)
  );

  // data memory: combinational read (zero in reset), synchronous write
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;
  assign mem_rd = rst ? mem[mem_a] : '0;

  function automatic logic [DATA_W-1:0] word(input int i);
    logic [31:0] w;
    w = 32'h1111_0000 + 32'(i);
    return {8{w}};
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wd, output bit acc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    acc = req_ready;
    if (acc) begin
      if (we) ref_mem[addr] = wd;
      else    exp_q.push_back(ref_mem[addr]);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 64 && !acc; n++) drive_cycle(we, addr, wd, acc);
    check1("send_accept", acc, 1'b1);
  endtask

  // scoreboard: compare each consumed response with the oldest expectation
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check1("rsp_unexpected", rsp_valid, 1'b0);
      else                   checkw("rsp_data", rsp_rdata, exp_q.pop_front());
    end
  end

  initial begin
    int n_acc;
    bit acc;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = INIT_WORD;
      ref_mem[i] = INIT_WORD;
    end
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(3);
    req_wdata = '0; rsp_ready = 1'b0;

    // reset with a request presented
    repeat (2) step();
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    checkn("rst_pending", int'(pending), 0);
    checkn("rst_mem_a", int'(mem_a), 0);
    checkw("rst_mem_wd", mem_wd, '0);
    checkw("rst_rsp_rdata", rsp_rdata, '0);
    rst = 1'b1; req_valid = 1'b0;
    step();
    checkn("post_rst_pending", int'(pending), 0);
    check1("post_rst_rsp_valid", rsp_valid, 1'b0);

    // init readback
    rsp_ready = 1'b1;
    send(1'b0, ADDR_W'(0), '0);
    checkn("ld0_pending", int'(pending), 1);
    checkn("ld0_mem_a", int'(mem_a), 0);
    check1("ld0_mem_we", mem_we, 1'b0);
    check1("ld0_rsp_early", rsp_valid, 1'b0);
    step();
    check1("ld0_rsp_valid", rsp_valid, 1'b1);
    checkw("ld0_rsp_rdata", rsp_rdata, INIT_WORD);
    step();
    check1("ld0_rsp_clear", rsp_valid, 1'b0);

    // read after write
    send(1'b1, ADDR_W'(5), A5_WORD);
    check1("raw_mem_we", mem_we, 1'b1);
    checkn("raw_mem_a", int'(mem_a), 5);
    checkw("raw_mem_wd", mem_wd, A5_WORD);
    send(1'b0, ADDR_W'(5), '0);
    step();
    check1("raw_rsp_valid", rsp_valid, 1'b1);
    checkw("raw_rsp_rdata", rsp_rdata, A5_WORD);
    step();

    // distinct contents for addresses 1..7
    for (int i = 1; i <= 7; i++) send(1'b1, ADDR_W'(i), word(i));
    step();
    checkn("preload_pending", int'(pending), 0);

    // back-pressure: six back-to-back loads against a stalled response port
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1'b0, ADDR_W'(i), '0, acc);
      n_acc += int'(acc);
    end
    checkn("bp_accepted", n_acc, 5);
    check1("bp_req_ready", req_ready, 1'b0);
    checkn("bp_pending", int'(pending), 4);
    check1("bp_rsp_valid", rsp_valid, 1'b1);
    checkw("bp_rsp_head", rsp_rdata, word(1));
    rsp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check1("bp_drain_valid", rsp_valid, 1'b1);
      checkn("bp_drain_pending", int'(pending), 4 - k);
    end
    step();
    check1("bp_drain_done", rsp_valid, 1'b0);

    // store retires while the response port is stalled
    rsp_ready = 1'b0;
    send(1'b0, ADDR_W'(0), '0);
    send(1'b1, ADDR_W'(7), X_WORD);
    check1("sus_mem_we", mem_we, 1'b1);
    checkn("sus_mem_a", int'(mem_a), 7);
    checkw("sus_mem_wd", mem_wd, X_WORD);
    check1("sus_rsp_valid", rsp_valid, 1'b1);
    send(1'b0, ADDR_W'(7), '0);
    checkn("sus_ld_pending", int'(pending), 1);
    check1("sus_ld_mem_we", mem_we, 1'b0);
    checkn("sus_ld_mem_a", int'(mem_a), 7);
    repeat (3) step();
    checkn("sus_hold_pending", int'(pending), 1);
    checkw("sus_hold_rdata", rsp_rdata, INIT_WORD);
    rsp_ready = 1'b1;
    step();
    checkn("sus_go_pending", int'(pending), 0);
    check1("sus_go_valid", rsp_valid, 1'b1);
    checkw("sus_go_rdata", rsp_rdata, X_WORD);
    step();
    check1("sus_done", rsp_valid, 1'b0);

    // reset in the middle of a stalled burst
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b0, ADDR_W'(i), '0);
    checkn("mid_pending", int'(pending), 3);
    check1("mid_rsp_valid", rsp_valid, 1'b1);
    rst = 1'b0;
    #1;
    check1("mid_rst_mem_we", mem_we, 1'b0);
    step();
    rst = 1'b1;
    exp_q.delete();
    checkn("mid_post_pending", int'(pending), 0);
    check1("mid_post_rsp_valid", rsp_valid, 1'b0);
    checkw("mid_post_rdata", rsp_rdata, '0);
    check1("mid_post_req_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    repeat (3) begin
      step();
      check1("mid_idle_mem_we", mem_we, 1'b0);
      check1("mid_idle_rsp_valid", rsp_valid, 1'b0);
    end
    send(1'b0, ADDR_W'(6), '0);
    step();
    check1("mid_next_valid", rsp_valid, 1'b1);
    checkw("mid_next_rdata", rsp_rdata, word(6));
    step();

    // random mix with random response back-pressure
    rand_ready = 1'b1;
    repeat (40) begin
      logic [31:0] r;
      r = $urandom();
      send(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), {8{r}});
    end
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
    checkn("drain_queue", exp_q.size(), 0);
    step();
    check1("drain_rsp_valid", rsp_valid, 1'b0);
    checkn("drain_pending", int'(pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
